// File: rtl/keyboard_pkg.sv
// keyboard_pkg: key codes, FSM states and BCD digit type shared by keyboard_entry.
package keyboard_pkg;
  localparam logic [3:0] KEY_CLEAR  = 4'hA;
  localparam logic [3:0] KEY_OP_MIN = 4'hB;
  localparam logic [3:0] KEY_OP_MAX = 4'hE;
  localparam logic [3:0] KEY_ENTER  = 4'hF;
  typedef enum logic [2:0] {IDLE, SETUP_NUM, PULSE_NUM, SETUP_OP, PULSE_OP} state_t;
  typedef logic [3:0] bcd_t;
endpackage

// File: rtl/bcd3_to_bin.sv
// bcd3_to_bin: three BCD digits to 8-bit binary, saturating at 255 with an overflow flag.
module bcd3_to_bin
  import keyboard_pkg::*;
(
  input  bcd_t       d2,
  input  bcd_t       d1,
  input  bcd_t       d0,
  output logic [7:0] bin,
  output logic       ovf
);
  logic [9:0] val;
  always_comb begin
    val = 10'(d2) * 10'd100 + 10'(d1) * 10'd10 + 10'(d0);
    ovf = val > 10'd255;
    bin = ovf ? 8'hFF : val[7:0];
  end
endmodule

// File: rtl/keyboard_entry.sv
// keyboard_entry: assembles up to three digits into a number and emits numbers/operators to mux_keyboard.
// Define KEYBOARD_ENTRY_BACKSPACE_EN to make key 0xA a backspace instead of a full clear.
module keyboard_entry
  import keyboard_pkg::*;
#(
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic [7:0] number,
  output logic [3:0] operand,
  output logic       op_ctrl,
  output logic       overflow
);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
  state_t state, state_n;
  bcd_t d2, d1, d0;
  logic [1:0] cnt;
  logic [3:0] gap, op_latch;
  logic pend_op, accept, is_digit, is_op, go_num, go_op, gap_done, ovf;
  logic [7:0] bin;
  bcd3_to_bin u_conv (.d2(d2), .d1(d1), .d0(d0), .bin(bin), .ovf(ovf));
  always_comb begin
    accept    = key_valid && key_ready;
    is_digit  = key_code <= 4'd9;
    is_op     = key_code >= KEY_OP_MIN && key_code <= KEY_OP_MAX;
    go_num    = accept && (is_op || key_code == KEY_ENTER) && cnt != 2'd0;
    go_op     = accept && is_op && cnt == 2'd0;
    gap_done  = gap == GAP_LAST;
    key_ready = state == IDLE;
    op_ctrl   = state == PULSE_NUM || state == PULSE_OP;
    state_n   = state;
    unique case (state)
      IDLE:      state_n = go_num ? SETUP_NUM : go_op ? SETUP_OP : IDLE;
      SETUP_NUM: state_n = gap_done ? PULSE_NUM : SETUP_NUM;
      PULSE_NUM: state_n = pend_op ? SETUP_OP : IDLE;
      SETUP_OP:  state_n = gap_done ? PULSE_OP : SETUP_OP;
      PULSE_OP:  state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      gap <= '0; d2 <= '0; d1 <= '0; d0 <= '0; cnt <= '0;
      op_latch <= '0; pend_op <= 1'b0;
      number <= '0; operand <= '0; overflow <= 1'b0;
    end else begin
      gap <= (state_n != state) ? 4'd0 : gap + 4'd1;
      if (go_num) begin
        number <= bin; overflow <= ovf; pend_op <= is_op; op_latch <= key_code;
        d2 <= '0; d1 <= '0; d0 <= '0; cnt <= '0;
      end else if (accept && is_digit && cnt != 2'd3) begin
        d2 <= d1; d1 <= d0; d0 <= key_code; cnt <= cnt + 2'd1;
`ifdef KEYBOARD_ENTRY_BACKSPACE_EN
      end else if (accept && key_code == KEY_CLEAR && cnt != 2'd0) begin
        d0 <= d1; d1 <= d2; d2 <= '0; cnt <= cnt - 2'd1;
`else
      end else if (accept && key_code == KEY_CLEAR) begin
        d2 <= '0; d1 <= '0; d0 <= '0; cnt <= '0;
`endif
      end
      if (go_op) operand <= key_code;
      if (state == PULSE_NUM) begin
        overflow <= 1'b0;
        if (pend_op) operand <= op_latch;
      end
    end
  end
endmodule
